// File: rtl/fft_frame_streamer_pkg.sv
// Shared types and helpers for the ping-pong FFT frame streamer.
// Holds the streaming state encoding and the bit-reverse index mapping.
package fft_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_e;

    // Reverse the low w bits of v; bits at or above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = v[w - 32'd1 - i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_streamer_if.sv
// Register-bus write port plus AXI4-Stream output of the frame streamer.
// master = streamer side (AXIS source, write-bus sink); slave = environment.
interface fft_frame_streamer_if #(
    parameter int SAMPLE_W = 32,
    parameter int AW       = 4
);
    logic [AW-1:0]         wAddr;
    logic [SAMPLE_W-1:0]   wData;
    logic                  wEn;
    logic                  tready;
    logic                  tvalid;
    logic                  tlast;
    logic [2*SAMPLE_W-1:0] tdata;

    modport master (
        input  wAddr, wData, wEn, tready,
        output tvalid, tlast, tdata
    );

    modport slave (
        output wAddr, wData, wEn, tready,
        input  tvalid, tlast, tdata
    );
endinterface

// File: rtl/fft_frame_streamer_pingpong_ram.sv
// Two-bank complex sample RAM: word-wide write port, sample-wide synchronous read.
// Bank select is the MSB of both addresses; write LSB picks RE (0) or IM (1).
module fft_pingpong_ram #(
    parameter int SAMPLE_W = 32,
    parameter int AW       = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW:0]           waddr_i,
    input  logic [SAMPLE_W-1:0]   wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [2*SAMPLE_W-1:0] rdata_o
);
    logic [SAMPLE_W-1:0]   re_mem [2**AW];
    logic [SAMPLE_W-1:0]   im_mem [2**AW];
    logic [2*SAMPLE_W-1:0] rdata_q;

    // Write one component and read one complex sample per cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (waddr_i[0]) begin
                im_mem[waddr_i[AW:1]] <= wdata_i;
            end else begin
                re_mem[waddr_i[AW:1]] <= wdata_i;
            end
        end
        rdata_q <= {im_mem[raddr_i], re_mem[raddr_i]};
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_streamer.sv
// Ping-pong FFT input stage: bus writer fills one bank while the other streams over AXIS.
// Define FFT_BITREV_EN to stream samples in bit-reversed index order.
module fft_frame_streamer
    import fft_stream_pkg::*;
#(
    parameter int NFFT     = 8,
    parameter int SAMPLE_W = 32,
    parameter int AW       = $clog2(2 * NFFT)
) (
    input  logic                 clk,
    input  logic                 resetn,
    fft_frame_streamer_if.master bus,
    input  logic                 commit,
    input  logic                 trig,
    input  logic                 auto_run,
    output logic                 streaming,
    output logic [1:0]           bank_full,
    output logic                 wr_drop
);
    localparam int LW = $clog2(NFFT);

    state_e                state_q;
    logic [LW-1:0]         idx_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  streaming_q;
    logic                  armed_q;
    logic                  rd_bank_q;
    logic [2*SAMPLE_W-1:0] tdata_q;

    logic                  wr_bank_q, wr_bank_d;
    logic                  wr_drop_q, wr_drop_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [1:0]            clr_mask_s, set_mask_s;

    logic                  hs_s, last_hs_s, start_s;
    logic                  wr_ok_s, wr_en_s, commit_ok_s;
    logic [LW-1:0]         fetch_idx_s, samp_idx_s;
    logic [AW-1:0]         rd_addr_s;
    logic [2*SAMPLE_W-1:0] ram_rdata_s;

    assign hs_s        = tvalid_q & bus.tready;
    assign last_hs_s   = hs_s & tlast_q;
    assign start_s     = (state_q == IDLE) & bank_full_q[rd_bank_q] & (armed_q | auto_run);
    assign wr_ok_s     = ~bank_full_q[wr_bank_q];
    assign wr_en_s     = bus.wEn & wr_ok_s;
    assign commit_ok_s = commit & wr_ok_s;

    // Bank bookkeeping: commits fill the write bank, the final handshake frees the read bank.
    always_comb begin
        clr_mask_s  = last_hs_s   ? (2'b01 << rd_bank_q) : 2'b00;
        set_mask_s  = commit_ok_s ? (2'b01 << wr_bank_q) : 2'b00;
        bank_full_d = (bank_full_q & ~clr_mask_s) | set_mask_s;
        wr_bank_d   = wr_bank_q ^ commit_ok_s;
        wr_drop_d   = wr_drop_q | (~wr_ok_s & (bus.wEn | commit));
    end

    // Write-side state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // Read-ahead: the RAM register always holds the beat after the one on tdata,
    // so a handshake fetches idx+2 and a stall re-reads idx+1.
    always_comb begin
        case (state_q)
            IDLE:    fetch_idx_s = {LW{1'b0}};
            LOAD:    fetch_idx_s = LW'(32'd1);
            STREAM:  fetch_idx_s = hs_s ? (idx_q + LW'(32'd2)) : (idx_q + LW'(32'd1));
            default: fetch_idx_s = {LW{1'b0}};
        endcase
    end

`ifdef FFT_BITREV_EN
    assign samp_idx_s = LW'(bitrev(32'(fetch_idx_s), LW));
`else
    assign samp_idx_s = fetch_idx_s;
`endif

    assign rd_addr_s = {rd_bank_q, samp_idx_s};

    fft_pingpong_ram #(
        .SAMPLE_W (SAMPLE_W),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en_s),
        .waddr_i ({wr_bank_q, bus.wAddr}),
        .wdata_i (bus.wData),
        .raddr_i (rd_addr_s),
        .rdata_o (ram_rdata_s)
    );

    // Streaming FSM with registered AXIS outputs and trigger arming.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= {LW{1'b0}};
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            streaming_q <= 1'b0;
            armed_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            tdata_q     <= {(2*SAMPLE_W){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q     <= STREAM;
                    idx_q       <= {LW{1'b0}};
                    tdata_q     <= ram_rdata_s;
                    tvalid_q    <= 1'b1;
                    tlast_q     <= 1'b0;
                    streaming_q <= 1'b1;
                end
                STREAM: begin
                    if (hs_s) begin
                        if (tlast_q) begin
                            state_q     <= IDLE;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            streaming_q <= 1'b0;
                            rd_bank_q   <= ~rd_bank_q;
                        end else begin
                            idx_q   <= idx_q + LW'(32'd1);
                            tdata_q <= ram_rdata_s;
                            tlast_q <= (idx_q == LW'(NFFT - 2));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (start_s) begin
                armed_q <= 1'b0;
            end else if (trig && !streaming_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign bus.tvalid = tvalid_q;
    assign bus.tlast  = tlast_q;
    assign bus.tdata  = tdata_q;
    assign streaming  = streaming_q;
    assign bank_full  = bank_full_q;
    assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer (NFFT=8, SAMPLE_W=32); honours FFT_BITREV_EN.
module tb_fft_frame_streamer;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       commit = 1'b0;
    logic       trig = 1'b0;
    logic       auto_run = 1'b0;
    logic       streaming;
    logic [1:0] bank_full;
    logic       wr_drop;

    int    errors = 0;
    int    checks = 0;
    int    pops = 0;
    beat_t exp_q[$];
`ifdef FFT_BITREV_EN
    int    ord_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int    ord_tab [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    fft_frame_streamer_if #(.SAMPLE_W(32), .AW(4)) bus ();

    fft_frame_streamer #(.NFFT(8), .SAMPLE_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .commit    (commit),
        .trig      (trig),
        .auto_run  (auto_run),
        .streaming (streaming),
        .bank_full (bank_full),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [31:0] d);
        bus.wAddr = a;
        bus.wData = d;
        bus.wEn   = 1'b1;
        tick();
        bus.wEn   = 1'b0;
    endtask

    task automatic fill(input logic [31:0] re_b, input logic [31:0] im_b);
        for (int k = 0; k < 8; k++) begin
            write_word(4'(2 * k), re_b + 32'(k));
            write_word(4'(2 * k + 1), im_b + 32'(k));
        end
    endtask

    task automatic do_commit(input bit ok, input logic [31:0] re_b, input logic [31:0] im_b);
        beat_t b;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                b.last = (i == 7);
                b.data = {im_b + 32'(ord_tab[i]), re_b + 32'(ord_tab[i])};
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic do_trig(input bit check_lat);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        if (check_lat) chk("lat_load_tvalid", 96'(bus.tvalid), 96'd0);
        tick();
        if (check_lat) chk("lat_stream_tvalid", 96'(bus.tvalid), 96'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats missing after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
        tick();
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic        stall_v = 1'b0;
    logic [64:0] held_v = 65'd0;
    beat_t       got_v;
    always @(negedge clk) begin
        if (!resetn) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) chk("stall_hold", 96'({bus.tvalid, bus.tlast, bus.tdata}), 96'({1'b1, held_v}));
            if (bus.tvalid && bus.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %0h expected no beat", bus.tdata);
                end else begin
                    got_v = exp_q.pop_front();
                    pops++;
                    if ({bus.tlast, bus.tdata} !== got_v) begin
                        errors++;
                        $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                                 bus.tlast, bus.tdata, got_v.last, got_v.data);
                    end
                end
            end
            stall_v = bus.tvalid && !bus.tready;
            held_v  = {bus.tlast, bus.tdata};
        end
    end

    initial begin
        int n, n_last, n_rise, base;
        bit seen_last;
        bus.wAddr  = 4'd0;
        bus.wData  = 32'd0;
        bus.wEn    = 1'b0;
        bus.tready = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_tvalid", 96'(bus.tvalid), 96'd0);
        chk("rst_tlast", 96'(bus.tlast), 96'd0);
        chk("rst_tdata", 96'(bus.tdata), 96'd0);
        chk("rst_streaming", 96'(streaming), 96'd0);
        chk("rst_bank_full", 96'(bank_full), 96'd0);
        chk("rst_wr_drop", 96'(wr_drop), 96'd0);
        resetn = 1'b1;
        tick();

        // Basic frame, tready held high
        bus.tready = 1'b1;
        fill(32'h0, 32'h100);
        do_commit(1'b1, 32'h0, 32'h100);
        chk("t1_bank_full_commit", 96'(bank_full), 96'd1);
        do_trig(1'b1);
        chk("t1_streaming", 96'(streaming), 96'd1);
        drain("t1");
        chk("t1_bank_full_end", 96'(bank_full), 96'd0);
        chk("t1_streaming_end", 96'(streaming), 96'd0);

        // Pseudo-random backpressure
        bus.tready = 1'b0;
        fill(32'h40, 32'h50);
        do_commit(1'b1, 32'h40, 32'h50);
        do_trig(1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            bus.tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.tready = 1'b1;
        drain("t2");
        chk("t2_bank_full_end", 96'(bank_full), 96'd0);

        // Fill second bank during a stalled stream, then back-to-back with auto_run
        bus.tready = 1'b0;
        fill(32'h600, 32'h700);
        do_commit(1'b1, 32'h600, 32'h700);
        do_trig(1'b1);
        fill(32'h800, 32'h900);
        do_commit(1'b1, 32'h800, 32'h900);
        chk("t3_both_full", 96'(bank_full), 96'd3);
        auto_run   = 1'b1;
        bus.tready = 1'b1;
        seen_last = 1'b0;
        n_last = 0;
        n_rise = -100;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!seen_last && bus.tvalid && bus.tready && bus.tlast) begin
                seen_last = 1'b1;
                n_last = c;
            end else if (seen_last && bus.tvalid) begin
                n_rise = c;
                break;
            end
        end
        chk("t3_gap", 96'(n_rise - n_last), 96'd3);
        drain("t3");
        auto_run = 1'b0;
        chk("t3_bank_full_end", 96'(bank_full), 96'd0);

        // Drops while both banks are full
        fill(32'hA00, 32'hB00);
        do_commit(1'b1, 32'hA00, 32'hB00);
        fill(32'hC00, 32'hD00);
        do_commit(1'b1, 32'hC00, 32'hD00);
        chk("t4_full", 96'(bank_full), 96'd3);
        chk("t4_no_drop_yet", 96'(wr_drop), 96'd0);
        write_word(4'd0, 32'hDEAD);
        chk("t4_write_drop", 96'(wr_drop), 96'd1);
        do_commit(1'b0, 32'h0, 32'h0);
        chk("t4_commit_ignored", 96'(bank_full), 96'd3);
        auto_run = 1'b1;
        drain("t4");
        auto_run = 1'b0;
        chk("t4_drop_sticky", 96'(wr_drop), 96'd1);
        chk("t4_bank_full_end", 96'(bank_full), 96'd0);

        // Reset at beat 3, then a fresh frame from beat 0
        fill(32'h3000, 32'h3100);
        do_commit(1'b1, 32'h3000, 32'h3100);
        base = pops;
        do_trig(1'b1);
        n = 0;
        while (pops != base + 3 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_reached_beat3", 96'(pops - base), 96'd3);
        resetn = 1'b0;
        tick();
        exp_q.delete();
        chk("t5_tvalid", 96'(bus.tvalid), 96'd0);
        chk("t5_tlast", 96'(bus.tlast), 96'd0);
        chk("t5_tdata", 96'(bus.tdata), 96'd0);
        chk("t5_streaming", 96'(streaming), 96'd0);
        chk("t5_bank_full", 96'(bank_full), 96'd0);
        chk("t5_wr_drop", 96'(wr_drop), 96'd0);
        resetn = 1'b1;
        tick();
        fill(32'h5000, 32'h5100);
        do_commit(1'b1, 32'h5000, 32'h5100);
        do_trig(1'b1);
        drain("t5");
        chk("t5_bank_full_end", 96'(bank_full), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Parametrised successor of the single-buffer FFT input stage.
- Double-buffered (ping-pong) complex-sample RAM: a register-bus writer fills one bank while the other streams to the FFT core over AXI4-Stream.
- Full per-beat tready backpressure, configurable sample width, trigger-driven or auto-run streaming, drop/status reporting.

Parameters:
- NFFT, 8, frame length in complex samples; power of two, >= 2.
- SAMPLE_W, 32, width of one real or imaginary component.
- AW, $clog2(2*NFFT), word address width (derived; do not override).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- wAddr  in  AW  word address in the write bank; even = RE[k], odd = IM[k], k = wAddr>>1.
- wData  in  SAMPLE_W  write data.
- wEn  in  1  write strobe.
- commit  in  1  single-cycle pulse: the write bank is complete.
- trig  in  1  single-cycle pulse: stream one full bank.
- auto_run  in  1  level: stream any full bank without trig.
- tready  in  1  AXIS ready.
- tvalid  out  1  AXIS valid.
- tlast  out  1  high on beat NFFT-1.
- tdata  out  2*SAMPLE_W  {IM, RE}.
- streaming  out  1  high from the first tvalid until the tlast handshake.
- bank_full  out  2  per-bank full flags.
- wr_drop  out  1  sticky; set by any dropped write or commit; cleared by reset only.

Behaviour:
- Reset values: resetn=0 at a clock edge forces tvalid=0, tlast=0, tdata=0, streaming=0, bank_full=0, wr_drop=0, wr_bank=0, rd_bank=0, armed=0, state=IDLE. Reset mid-frame aborts the frame immediately. RAM contents are not cleared.
- Write side:
  - A wEn write goes to bank wr_bank only when bank_full[wr_bank]=0; otherwise it is dropped and wr_drop is set.
  - commit with bank_full[wr_bank]=0: set bank_full[wr_bank] and toggle wr_bank.
  - commit with bank_full[wr_bank]=1: ignored; wr_drop is set.
- Arming: a trig pulse sets armed. A trig while armed or streaming is ignored (no queueing).
- State machine, one transition per cycle:
  - IDLE -> LOAD when bank_full[rd_bank] && (armed || auto_run). armed clears on this transition.
  - LOAD: issue a synchronous RAM read of sample 0, idx=0.
  - LOAD -> STREAM: tdata = {IM[0], RE[0]}, tvalid=1, streaming=1. tvalid therefore asserts 2 cycles after the trig edge when the bank is already full.
  - STREAM: on tvalid&&tready, present the next sample on the following cycle. No bubbles while tready=1, using a read-ahead / skid register. tdata, tvalid and tlast hold stable while tready=0.
  - tlast = (idx == NFFT-1).
  - On the tlast handshake: tvalid=0, tlast=0, streaming=0, clear bank_full[rd_bank], toggle rd_bank, return to IDLE. The next frame may start on the following cycle (IDLE -> LOAD).
- Simultaneous events:
  - commit in the same cycle as the tlast handshake on the other bank: both take effect.
  - commit and trig in the same cycle with bank_full[rd_bank]=0: trig arms, and the frame starts once that bank becomes full.
- Writes never touch rd_bank, because that bank is full while streaming.
- Width rules: idx is $clog2(NFFT) bits and wraps only at the frame end.

Optional Feature:
- FFT_BITREV_EN:
  - Defined: sample k streamed at beat i is k = bitreverse(i) over $clog2(NFFT) bits, for a natural-order-output FFT core.
  - Undefined: natural order, k = i.
  - tlast, timing and handshake are identical in both builds.

Decomposition:
- Package fft_stream_pkg: state enum (IDLE, LOAD, STREAM) and a bit-reverse function.
- Sub-module fft_pingpong_ram: two banks, 1 write port, 1 synchronous read port; the bank-select bit is the MSB of both addresses.

Test Plan:
- Reset then write RE[k]=k, IM[k]=0x100+k for NFFT=8; commit; trig -> tvalid rises 2 cycles after trig; 8 beats with tdata={0x100+i, i}; tlast only on beat 7; bank_full returns to 00.
- tready toggling 1,0,0,1 pseudo-randomly -> no beat lost or duplicated; tdata stable while tready=0; frame order intact.
- Fill bank0, commit, fill bank1 with different data during streaming, commit, auto_run=1 -> two back-to-back frames, the second starting 2 cycles after the first tlast.
- Both banks full, then wEn and commit -> writes dropped, RAM unchanged, wr_drop=1 and sticky.
- resetn=0 at beat 3 -> outputs zero next cycle, bank_full=00; a new commit plus trig streams correctly from beat 0.
- FFT_BITREV_EN build, NFFT=8 -> RE order 0,4,2,6,1,5,3,7.
